// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM state type and the byte-enable helper
// used by the slave memory.
package ahb_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HrespOkay  = 2'b00,
    HrespError = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    HsizeByte  = 3'd0,
    HsizeHalf  = 3'd1,
    HsizeWord  = 3'd2,
    HsizeDword = 3'd3
  } hsize_e;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } slave_state_e;

  // Byte enables for a transfer of 2^size bytes starting at byte lane 'lane' (up to 8 lanes).
  function automatic logic [7:0] byte_enables(input logic [2:0] size, input logic [2:0] lane);
    logic [7:0] mask;
    case (size)
      HsizeByte: mask = 8'h01;
      HsizeHalf: mask = 8'h03;
      HsizeWord: mask = 8'h0F;
      default:   mask = 8'hFF;
    endcase
    return mask << lane;
  endfunction

endpackage

// File: rtl/ahb_slave_mem_array.sv
// DEPTH x DATA_W storage: synchronous byte-enable write port, asynchronous read port.
// Contents are intentionally not reset.
module ahb_slave_mem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned NBYTES = DATA_W / 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [NBYTES-1:0] i_be,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (i_be[b]) begin
          r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave memory with programmable wait states, byte-lane writes and a
// two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       DEPTH       = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       WAIT_STATES = 0
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic              hreadyin,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [2:0]        hburst,
  input  logic [2:0]        hsize,
  input  logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic [1:0]        hresp
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(NBYTES);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [63:0] SPAN   = 64'(DEPTH) * 64'(NBYTES);
  localparam logic [63:0] BASE64 = 64'(BASE_ADDR);

  slave_state_e      r_state;
  logic [3:0]        r_cnt;
  logic [AW-1:0]     r_word;
  logic [LANE_W-1:0] r_lane;
  logic [2:0]        r_size;
  logic              r_write;
  logic              r_hreadyout;
  hresp_e            r_hresp;
  logic [DATA_W-1:0] r_hrdata;

  logic [63:0]       w_addr64;
  logic [63:0]       w_off;
  logic              w_out_of_range;
  logic              w_size_bad;
  logic [LANE_W-1:0] w_align_mask;
  logic              w_misalign;
  logic              w_illegal;
  logic              w_can_accept;
  logic              w_accept;
  logic              w_we;
  logic [NBYTES-1:0] w_be;
  logic [DATA_W-1:0] w_rdata;
  logic              w_unused;

  // Decode in 64 bits so BASE_ADDR + span cannot wrap at the top of the address space.
  assign w_addr64       = 64'(haddr);
  assign w_off          = w_addr64 - BASE64;
  assign w_out_of_range = (w_addr64 < BASE64) || (w_off >= SPAN);
  assign w_size_bad     = hsize > 3'(LANE_W);
  assign w_align_mask   = LANE_W'((8'h01 << hsize) - 8'h01);
  assign w_misalign     = |(haddr[LANE_W-1:0] & w_align_mask);
  assign w_illegal      = w_out_of_range | w_size_bad | w_misalign;

  assign w_can_accept = (r_state == StIdle) || (r_state == StData) || (r_state == StErr2);
  assign w_accept     = w_can_accept & hsel & hreadyin &
                        ((htrans == HtransNonseq) || (htrans == HtransSeq));

  // A write whose DATA edge coincides with reset is dropped.
  assign w_we = (r_state == StData) && r_write && !hreset;
  assign w_be = NBYTES'(byte_enables(r_size, 3'(r_lane)));

  assign w_unused = ^{hburst, w_off};

  ahb_slave_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .i_clk   (hclk),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_waddr (r_word),
    .i_wdata (hwdata),
    .i_raddr (r_word),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state     <= StIdle;
      r_cnt       <= 4'd0;
      r_word      <= '0;
      r_lane      <= '0;
      r_size      <= 3'd0;
      r_write     <= 1'b0;
      r_hreadyout <= 1'b1;
      r_hresp     <= HrespOkay;
      r_hrdata    <= '0;
    end else begin
      case (r_state)
        StIdle, StData, StErr2: begin
          if ((r_state == StData) && !r_write) begin
            r_hrdata <= w_rdata;
          end
          if (w_accept) begin
            r_word  <= w_off[AW+LANE_W-1:LANE_W];
            r_lane  <= haddr[LANE_W-1:0];
            r_size  <= hsize;
            r_write <= hwrite;
            r_cnt   <= 4'd0;
            if (w_illegal) begin
              r_state     <= StErr1;
              r_hreadyout <= 1'b0;
              r_hresp     <= HrespError;
            end else if (WAIT_STATES > 0) begin
              r_state     <= StWait;
              r_hreadyout <= 1'b0;
              r_hresp     <= HrespOkay;
            end else begin
              r_state     <= StData;
              r_hreadyout <= 1'b1;
              r_hresp     <= HrespOkay;
            end
          end else begin
            r_state     <= StIdle;
            r_hreadyout <= 1'b1;
            r_hresp     <= HrespOkay;
          end
        end
        StWait: begin
          if (r_cnt == 4'(WAIT_STATES - 1)) begin
            r_state     <= StData;
            r_hreadyout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        StErr1: begin
          r_state     <= StErr2;
          r_hreadyout <= 1'b1;
          r_hresp     <= HrespError;
        end
        default: begin
          r_state     <= StIdle;
          r_hreadyout <= 1'b1;
          r_hresp     <= HrespOkay;
        end
      endcase
    end
  end

  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;
  // Read data is live from the array in a DATA-read cycle and held otherwise.
  assign hrdata    = ((r_state == StData) && !r_write) ? w_rdata : r_hrdata;

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
Parametrised AHB-Lite slave memory: next-generation endpoint for the APB-AHB bridge environment, replacing a fixed-width signal bundle with a real responding slave. Configurable data width, depth, base address and wait states. Byte-lane writes by hsize/haddr, and a two-cycle ERROR response for illegal transfers. Sits on the AHB side of the bridge as the reference slave the bench drives and monitors.

Parameters:
ADDR_W, 32, haddr width
DATA_W, 32, hwdata/hrdata width; legal values 32 or 64
DEPTH, 1024, memory depth in DATA_W-bit words
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DATA_W/8-aligned
WAIT_STATES, 0, hreadyout-low cycles inserted per OKAY data phase; legal range 0..15

Ports:
hclk  in  1  clock, all logic on posedge
hreset  in  1  synchronous, active-high reset
hsel  in  1  slave select, qualifies the address phase
htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
hwrite  in  1  1=write, 0=read
hreadyin  in  1  bus ready; address phase taken only when high
haddr  in  ADDR_W  byte address
hburst  in  3  burst type; informational only, each beat is decoded independently
hsize  in  3  log2 of transfer bytes
hwdata  in  DATA_W  write data, valid in the data phase
hrdata  out  DATA_W  read data
hreadyout  out  1  transfer-complete strobe
hresp  out  2  OKAY=00, ERROR=01

Behaviour:
- Interface decision: one clock, hclk; reset, hreset, is synchronous and active-high.
- Reset values: hreadyout=1, hresp=OKAY, hrdata=0, FSM=IDLE, wait counter=0. Memory contents are not reset.
- Accept rule: an address phase is accepted on a posedge when hsel & hreadyin & htrans[1]=1.
  - On accept, register haddr, hwrite and hsize.
  - IDLE/BUSY transfers, or an unselected slave, produce a zero-wait OKAY response.
- Illegal transfer, detected at accept:
  - address out of range: haddr < BASE_ADDR or haddr >= BASE_ADDR + DEPTH*DATA_W/8; or
  - hsize > log2(DATA_W/8); or
  - haddr not aligned to 2^hsize.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: accept of a legal transfer goes to WAIT if WAIT_STATES>0, otherwise DATA. Accept of an illegal transfer goes to ERR1.
  - WAIT: hreadyout=0, hresp=OKAY. Counter counts WAIT_STATES cycles, then the FSM goes to DATA.
  - DATA: hreadyout=1, hresp=OKAY. The transfer completes at the posedge.
    - Write: bytes selected by the registered haddr/hsize are written from hwdata.
    - Read: hrdata carries the word at the registered address (combinational from the array); all lanes are driven.
    - Next state: a new accept on the same edge gives back-to-back pipelining (to WAIT, DATA or ERR1); otherwise IDLE.
  - ERR1: hreadyout=0, hresp=ERROR. Always goes to ERR2. No write occurs.
  - ERR2: hreadyout=1, hresp=ERROR. A new address phase may be accepted here, with the same transitions as DATA.
- Byte lanes: lane index = haddr[log2(DATA_W/8)-1:0]. Writes modify exactly 2^hsize bytes starting at that lane; other bytes are preserved.
- Read-after-write: a write completing on edge N is visible to a read whose data phase follows edge N. No forwarding is needed because the write commits at the DATA edge.
- hrdata outside a DATA-read cycle holds its last value.
- Reset mid-transfer returns the FSM to IDLE on the next edge. An in-flight write whose DATA edge coincides with hreset is discarded.
- hburst is unused beyond decode; wrap and increment address generation is the master's job.

Decomposition:
- Shared package ahb_pkg holds:
  - htrans_e, hresp_e and hsize_e encodings;
  - the slave FSM typedef;
  - the function computing byte enables from hsize and the address lanes.
- Sub-module ahb_slave_mem_array: DEPTH x DATA_W array with a synchronous byte-enable write port and an asynchronous read port.
- FSM, decode and error logic stay in the top module.

Test Plan:
- Reset: assert hreset for 2 cycles -> hreadyout=1, hresp=00, hrdata=0 on every cycle while asserted.
- Word write then read, WAIT_STATES=0, DATA_W=32: NONSEQ write 0x10 with 0xDEADBEEF, then NONSEQ read 0x10 -> hrdata=0xDEADBEEF, both with zero waits and OKAY.
- Byte-lane write: write word 0x20=0x11223344, then byte write (hsize=0) to 0x22 of 0xAA -> read 0x20 returns 0x11AA3344.
- Wait states, WAIT_STATES=3: single read -> hreadyout low for exactly 3 cycles, then high with OKAY. A 4-beat INCR burst takes 16 data-phase cycles in total.
- Error: read 0x1000 with DEPTH=1024 (out of range), then halfword at 0x01 (misaligned) -> each gives ERR1 (hreadyout=0, hresp=01) then ERR2 (hreadyout=1, hresp=01). Memory is unchanged.
- Pipelined back-to-back with reset: write 0x30 in the address phase during the DATA cycle of read 0x2C, then assert hreset on the write's DATA edge -> 0x30 keeps its old value and the FSM is IDLE.
